detector_frame_ctrl: RTL and testbench
======================================

Name: detector_frame_ctrl

Overview:
- Frame-level controller for the serial "111" sequence detector (Mealy, overlapping).
- Accepts a parallel word on a start request and shifts it MSB-first through an embedded detector, one bit per clock.
- Counts detections and records the position of the first hit.
- Reports results with a one-cycle done pulse. Lets software/upper logic scan whole words instead of driving the serial x input bit by bit.

Parameters:
- WIDTH, 8, frame length in bits (>=3).
- CNT_W, 4, match counter width; counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to scan din; sampled only in IDLE.
- din  input  WIDTH  frame to scan; captured on accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse in DONE state.
- found  output  1  at least one match in last completed frame.
- match_cnt  output  CNT_W  number of matches in last frame (saturating).
- first_pos  output  $clog2(WIDTH)  bit index (0 = MSB, first shifted) of the first match.
- ser_x  output  1  bit currently presented to detector (debug).
- ser_y  output  1  combinational Mealy detector output (debug).

Behaviour:
- Reset (async, any state): FSM=IDLE; shift register, bit index, and detector state cleared to S0; busy=0, done=0, found=0, match_cnt=0, first_pos=0. ser_x=0 and ser_y=0 immediately.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge k:
  - din captured; bit index=0; detector state=S0.
  - match_cnt, found, first_pos cleared.
  - Next state SHIFT.
- IDLE, start=0: hold; result outputs keep last frame's values.
- SHIFT:
  - ser_x = shreg[WIDTH-1]; shreg shifts left by 1 each edge.
  - Bit index increments each edge.
  - After the edge that consumes index WIDTH-1, next state is DONE.
  - SHIFT lasts exactly WIDTH cycles (edges k+1..k+WIDTH).
- Detector, next state on ser_x:
  - S0: x=1 -> S1, else S0.
  - S1: x=1 -> S2, else S0.
  - S2: x=1 -> S2, else S0. S2 self-loop gives overlap.
- ser_y = (state==S2) && ser_x && (FSM==SHIFT). Mealy output: asserted in the same cycle as the third consecutive 1.
- On each edge with ser_y=1:
  - match_cnt increments, holding at all-ones once saturated.
  - If found==0: first_pos <= bit index and found <= 1.
- DONE:
  - done=1 for exactly one cycle (cycle k+WIDTH+1); busy=0.
  - Next state IDLE.
  - Results are valid from DONE onward and stable until the next accepted start.
- start in SHIFT or DONE is ignored (no queuing).
- start in the IDLE cycle right after DONE is accepted: back-to-back frames, 1 idle cycle minimum.
- Detector state does not carry across frames; it is reset to S0 on every accepted start.
- ser_x=0 and ser_y=0 outside SHIFT.
- din changes after capture have no effect on the frame in progress.
- Reset asserted mid-SHIFT aborts the frame; no done pulse; all results cleared.

Test Plan:
- WIDTH=8, din=8'b11100000, start 1 cycle -> busy high 8 cycles; ser_y high only at index 2; done pulse at k+9; match_cnt=1, found=1, first_pos=2.
- din=8'hFF -> ser_y high at indices 2..7; match_cnt=6, first_pos=2, found=1.
- din=8'b11011011 -> no ser_y; match_cnt=0, found=0, first_pos=0. Then din=8'b01110111 back-to-back (start the cycle after done) -> match_cnt=2, first_pos=3.
- WIDTH=32, CNT_W=3, din=all ones -> 30 raw hits; match_cnt saturates at 7; first_pos=2.
- Frame din=8'hFF started, start pulsed again and din changed to 8'h00 during SHIFT -> both ignored; results as for 8'hFF.
- rst asserted at SHIFT index 4 of 8'hFF -> outputs 0 immediately, no done pulse. Next start with 8'b00000111 -> match_cnt=1, first_pos=7.

Source files
------------

// File: rtl/detector_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : detector_frame_ctrl_if
// Purpose  : Request/result bundle between a frame requester and the
//            detector_frame_ctrl block. The requester drives start/din.
//            The controller returns status, results and serial debug taps.
// Revision : 1.0 - initial release
// ============================================================================
interface detector_frame_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    // Bit-index width. It is kept at least one bit wide, so a degenerate WIDTH
    // still elaborates.
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             start;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic             found;
    logic [CNT_W-1:0] match_cnt;
    logic [IDX_W-1:0] first_pos;
    logic             ser_x;
    logic             ser_y;

    // Requester side: issues frames and observes results.
    modport master (
        output start,
        output din,
        input  busy,
        input  done,
        input  found,
        input  match_cnt,
        input  first_pos,
        input  ser_x,
        input  ser_y
    );

    // Controller side: accepts frames and reports results.
    modport slave (
        input  start,
        input  din,
        output busy,
        output done,
        output found,
        output match_cnt,
        output first_pos,
        output ser_x,
        output ser_y
    );
endinterface : detector_frame_ctrl_if
`default_nettype wire

// File: rtl/detector_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : detector_frame_ctrl
// Purpose  : Frame-level controller around an overlapping Mealy "111"
//            detector. A start request captures a parallel word. The word is
//            shifted MSB-first through the detector, one bit per clock.
//            The block counts hits (with saturation) and records the index of
//            the first hit. It ends each frame with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module detector_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    detector_frame_ctrl_if.slave   bus
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Frame sequencer encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // Detector encoding: number of consecutive ones seen, capped at two
    localparam logic [1:0] c_DET_S0 = 2'd0;
    localparam logic [1:0] c_DET_S1 = 2'd1;
    localparam logic [1:0] c_DET_S2 = 2'd2;

    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [1:0]       det_q,    det_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             found_q,  found_d;
    logic [IDX_W-1:0] pos_q,    pos_d;

    logic             w_in_shift;
    logic             w_ser_x;
    logic             w_ser_y;
    logic [1:0]       w_det_next;

    // Serial taps. Both are forced low outside SHIFT, so idle cycles never
    // look like data.
    always_comb begin
        w_in_shift = (state_q == c_ST_SHIFT);
        w_ser_x    = w_in_shift & shreg_q[WIDTH-1];
        w_ser_y    = w_in_shift & (det_q == c_DET_S2) & shreg_q[WIDTH-1];
    end

    // Detector transition on the presented bit. S2 loops on 1 so overlapping runs keep hitting.
    always_comb begin
        w_det_next = c_DET_S0;
        case (det_q)
            c_DET_S0: w_det_next = w_ser_x ? c_DET_S1 : c_DET_S0;
            c_DET_S1: w_det_next = w_ser_x ? c_DET_S2 : c_DET_S0;
            c_DET_S2: w_det_next = w_ser_x ? c_DET_S2 : c_DET_S0;
            default:  w_det_next = c_DET_S0;
        endcase
    end

    // Frame sequencing and datapath next-state
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        det_d   = det_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        pos_d   = pos_q;

        case (state_q)
            c_ST_IDLE: begin
                // Results from the previous frame stay visible until a new
                // frame is accepted.
                if (bus.start) begin
                    state_d = c_ST_SHIFT;
                    shreg_d = bus.din;
                    idx_d   = '0;
                    det_d   = c_DET_S0;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    pos_d   = '0;
                end
            end

            c_ST_SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                idx_d   = idx_q + 1'b1;
                det_d   = w_det_next;
                if (w_ser_y) begin
                    if (cnt_q != c_CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (!found_q) begin
                        found_d = 1'b1;
                        pos_d   = idx_q;
                    end
                end
                if (idx_q == c_IDX_LAST) begin
                    state_d = c_ST_DONE;
                end
            end

            c_ST_DONE: begin
                // Requests in this state are dropped. The earliest new frame starts
                // in the following IDLE cycle.
                state_d = c_ST_IDLE;
            end

            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // State registers. Reset aborts any frame in flight and clears all results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            det_q   <= c_DET_S0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            det_q   <= det_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            pos_q   <= pos_d;
        end
    end

    assign bus.busy      = w_in_shift;
    assign bus.done      = (state_q == c_ST_DONE);
    assign bus.found     = found_q;
    assign bus.match_cnt = cnt_q;
    assign bus.first_pos = pos_q;
    assign bus.ser_x     = w_ser_x;
    assign bus.ser_y     = w_ser_y;

endmodule : detector_frame_ctrl
`default_nettype wire

// File: tb/tb_detector_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_detector_frame_ctrl
// Purpose  : Directed self-checking bench for detector_frame_ctrl. It uses an
//            8-bit/4-bit instance for most scenarios and a 32-bit/3-bit
//            instance for counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_detector_frame_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    detector_frame_ctrl_if #(.WIDTH(8),  .CNT_W(4)) if8 ();
    detector_frame_ctrl_if #(.WIDTH(32), .CNT_W(3)) if32 ();

    detector_frame_ctrl #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    detector_frame_ctrl #(.WIDTH(32), .CNT_W(3)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (if32.slave)
    );

    int          errors = 0;
    int          checks = 0;

    // Observations gathered by run8 for the calling scenario to judge
    int          busy_cycles;
    int          done_at;
    int          done_pulses;
    logic [31:0] ymask;
    logic [31:0] xmask;

    // Issue one 8-bit frame and record the frame. ymask/xmask bit i holds
    // ser_y/ser_x at shift index i. done_at counts cycles after the accept
    // edge. With disturb set, start is pulsed and din is zeroed mid-frame.
    task automatic run8(input logic [7:0] d, input bit disturb);
        int cyc;
        busy_cycles = 0;
        done_at     = 0;
        done_pulses = 0;
        ymask       = '0;
        xmask       = '0;
        @(negedge clk);
        if8.start = 1'b1;
        if8.din   = d;
        cyc = 0;
        while (cyc < 20 && done_at == 0) begin
            @(negedge clk);
            cyc++;
            if8.start = 1'b0;
            if (disturb && cyc == 3) begin
                if8.start = 1'b1;
                if8.din   = 8'h00;
            end
            if (if8.busy) begin
                if (if8.ser_y) ymask[busy_cycles] = 1'b1;
                if (if8.ser_x) xmask[busy_cycles] = 1'b1;
                busy_cycles++;
            end
            if (if8.done) begin
                done_pulses++;
                done_at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", if8.busy); end
        checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", if8.done); end
        checks++; if (if8.found !== 1'b0) begin errors++; $display("FAIL reset_found: got %0b expected 0", if8.found); end
        checks++; if (if8.match_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", if8.match_cnt); end
        checks++; if (if8.first_pos !== 3'd0) begin errors++; $display("FAIL reset_pos: got %0d expected 0", if8.first_pos); end
        checks++; if (if8.ser_x !== 1'b0 || if8.ser_y !== 1'b0) begin errors++; $display("FAIL reset_ser: got x=%0b y=%0b expected 0 0", if8.ser_x, if8.ser_y); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (if8.busy !== 1'b0 || if32.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b/%0b expected 0/0", if8.busy, if32.busy); end
    endtask

    task automatic test_single_run();
        run8(8'b1110_0000, 1'b0);
        checks++; if (busy_cycles !== 8) begin errors++; $display("FAIL single_busy_cycles: got %0d expected 8", busy_cycles); end
        checks++; if (done_at !== 9) begin errors++; $display("FAIL single_done_at: got %0d expected 9", done_at); end
        checks++; if (ymask !== 32'h0000_0004) begin errors++; $display("FAIL single_ymask: got %h expected 00000004", ymask); end
        checks++; if (xmask !== 32'h0000_0007) begin errors++; $display("FAIL single_xmask: got %h expected 00000007", xmask); end
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL single_busy_in_done: got %0b expected 0", if8.busy); end
        checks++; if (if8.match_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", if8.match_cnt); end
        checks++; if (if8.found !== 1'b1) begin errors++; $display("FAIL single_found: got %0b expected 1", if8.found); end
        checks++; if (if8.first_pos !== 3'd2) begin errors++; $display("FAIL single_pos: got %0d expected 2", if8.first_pos); end
        // The done pulse is one cycle wide, and results hold while idle.
        repeat (3) @(negedge clk);
        checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %0b expected 0", if8.done); end
        checks++; if (if8.match_cnt !== 4'd1 || if8.first_pos !== 3'd2) begin errors++; $display("FAIL single_hold: got cnt=%0d pos=%0d expected 1 2", if8.match_cnt, if8.first_pos); end
        checks++; if (if8.ser_x !== 1'b0 || if8.ser_y !== 1'b0) begin errors++; $display("FAIL single_idle_ser: got x=%0b y=%0b expected 0 0", if8.ser_x, if8.ser_y); end
    endtask

    task automatic test_all_ones();
        run8(8'hFF, 1'b0);
        checks++; if (ymask !== 32'h0000_00FC) begin errors++; $display("FAIL ones_ymask: got %h expected 000000fc", ymask); end
        checks++; if (if8.match_cnt !== 4'd6) begin errors++; $display("FAIL ones_cnt: got %0d expected 6", if8.match_cnt); end
        checks++; if (if8.first_pos !== 3'd2 || if8.found !== 1'b1) begin errors++; $display("FAIL ones_pos_found: got pos=%0d found=%0b expected 2 1", if8.first_pos, if8.found); end
    endtask

    task automatic test_back_to_back();
        run8(8'b1101_1011, 1'b0);
        checks++; if (ymask !== 32'h0) begin errors++; $display("FAIL b2b_a_ymask: got %h expected 00000000", ymask); end
        checks++; if (if8.match_cnt !== 4'd0 || if8.found !== 1'b0 || if8.first_pos !== 3'd0) begin errors++; $display("FAIL b2b_a_results: got cnt=%0d found=%0b pos=%0d expected 0 0 0", if8.match_cnt, if8.found, if8.first_pos); end
        // run8 returns in the DONE cycle, so this start lands in the first IDLE cycle.
        run8(8'b0111_0111, 1'b0);
        checks++; if (done_at !== 9) begin errors++; $display("FAIL b2b_b_done_at: got %0d expected 9", done_at); end
        checks++; if (ymask !== 32'h0000_0088) begin errors++; $display("FAIL b2b_b_ymask: got %h expected 00000088", ymask); end
        checks++; if (if8.match_cnt !== 4'd2) begin errors++; $display("FAIL b2b_b_cnt: got %0d expected 2", if8.match_cnt); end
        checks++; if (if8.first_pos !== 3'd3 || if8.found !== 1'b1) begin errors++; $display("FAIL b2b_b_pos_found: got pos=%0d found=%0b expected 3 1", if8.first_pos, if8.found); end
    endtask

    task automatic test_saturation();
        int cyc;
        int hits;
        int busy32;
        int done32;
        hits   = 0;
        busy32 = 0;
        done32 = 0;
        @(negedge clk);
        if32.start = 1'b1;
        if32.din   = 32'hFFFF_FFFF;
        cyc = 0;
        while (cyc < 50 && done32 == 0) begin
            @(negedge clk);
            cyc++;
            if32.start = 1'b0;
            if (if32.busy) busy32++;
            if (if32.ser_y) hits++;
            if (if32.done) done32 = cyc;
        end
        checks++; if (busy32 !== 32) begin errors++; $display("FAIL sat_busy_cycles: got %0d expected 32", busy32); end
        checks++; if (done32 !== 33) begin errors++; $display("FAIL sat_done_at: got %0d expected 33", done32); end
        checks++; if (hits !== 30) begin errors++; $display("FAIL sat_raw_hits: got %0d expected 30", hits); end
        checks++; if (if32.match_cnt !== 3'd7) begin errors++; $display("FAIL sat_cnt: got %0d expected 7", if32.match_cnt); end
        checks++; if (if32.first_pos !== 5'd2 || if32.found !== 1'b1) begin errors++; $display("FAIL sat_pos_found: got pos=%0d found=%0b expected 2 1", if32.first_pos, if32.found); end
    endtask

    task automatic test_ignore_start();
        run8(8'hFF, 1'b1);
        checks++; if (done_pulses !== 1 || done_at !== 9) begin errors++; $display("FAIL ign_done: got pulses=%0d at=%0d expected 1 9", done_pulses, done_at); end
        checks++; if (ymask !== 32'h0000_00FC || xmask !== 32'h0000_00FF) begin errors++; $display("FAIL ign_masks: got y=%h x=%h expected 000000fc 000000ff", ymask, xmask); end
        checks++; if (if8.match_cnt !== 4'd6 || if8.first_pos !== 3'd2) begin errors++; $display("FAIL ign_results: got cnt=%0d pos=%0d expected 6 2", if8.match_cnt, if8.first_pos); end
        // The mid-frame start was dropped, so no second frame may follow.
        @(negedge clk);
        @(negedge clk);
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL ign_no_requeue: got busy=%0b expected 0", if8.busy); end
    endtask

    task automatic test_reset_mid_shift();
        int extra_done;
        extra_done = 0;
        @(negedge clk);
        if8.start = 1'b1;
        if8.din   = 8'hFF;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (4) @(negedge clk);
        // Shift index 4 is on the bus now. Indices 2 and 3 have already been counted.
        checks++; if (if8.ser_y !== 1'b1 || if8.match_cnt !== 4'd2) begin errors++; $display("FAIL rstmid_pre: got y=%0b cnt=%0d expected 1 2", if8.ser_y, if8.match_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin errors++; $display("FAIL rstmid_status: got busy=%0b done=%0b expected 0 0", if8.busy, if8.done); end
        checks++; if (if8.ser_x !== 1'b0 || if8.ser_y !== 1'b0) begin errors++; $display("FAIL rstmid_ser: got x=%0b y=%0b expected 0 0", if8.ser_x, if8.ser_y); end
        checks++; if (if8.match_cnt !== 4'd0 || if8.found !== 1'b0 || if8.first_pos !== 3'd0) begin errors++; $display("FAIL rstmid_results: got cnt=%0d found=%0b pos=%0d expected 0 0 0", if8.match_cnt, if8.found, if8.first_pos); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (if8.done) extra_done++;
        end
        checks++; if (extra_done !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", extra_done); end
        run8(8'b0000_0111, 1'b0);
        checks++; if (ymask !== 32'h0000_0080) begin errors++; $display("FAIL rstmid_next_ymask: got %h expected 00000080", ymask); end
        checks++; if (if8.match_cnt !== 4'd1 || if8.first_pos !== 3'd7 || if8.found !== 1'b1) begin errors++; $display("FAIL rstmid_next_results: got cnt=%0d pos=%0d found=%0b expected 1 7 1", if8.match_cnt, if8.first_pos, if8.found); end
    endtask

    initial begin
        rst        = 1'b1;
        if8.start  = 1'b0;
        if8.din    = '0;
        if32.start = 1'b0;
        if32.din   = '0;
        test_reset();
        test_single_run();
        test_all_ones();
        test_back_to_back();
        test_saturation();
        test_ignore_start();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_detector_frame_ctrl
`default_nettype wire
